// File: rtl/order_sequencer.sv
// order_sequencer
//   Consumer end of the order cache. On task_start it pops orders one at a time,
//   samples each latched order code, launches the matching compute engine and
//   waits for engine_done before popping the next order. Code 5 ends the list.
//   All outputs are registered.
//
// Ports
//   system_clk       clock
//   rst_n            synchronous active-low reset
//   task_start       start of task list (IDLE only)
//   abort            return to IDLE, clear error (highest priority)
//   calculate_start  cache strobe, order valid this cycle (checked in LATCH)
//   order[2:0]       latched order code: 1..4 engine op, 5 end, others illegal
//   engine_done      one-cycle done pulse from the selected engine
//   pop_order_en     one-cycle pop request to the cache
//   engine_start     one-cycle engine launch pulse
//   engine_sel[2:0]  order code of the launched op, held until next dispatch
//   task_busy        high in POP/LATCH/DISPATCH/BUSY/FINISH
//   task_done        one-cycle pulse after the end code
//   task_error       high in ERROR
//   err_code[2:0]    1 illegal order, 2 overflow, 3 watchdog, 4 missing strobe
//   order_count      orders dispatched in the current task
module order_sequencer #(
    parameter int CNT_W      = 10,
    parameter int MAX_ORDERS = 512,
    parameter int WDOG_W     = 24
) (
    input  logic             system_clk,
    input  logic             rst_n,
    input  logic             task_start,
    input  logic             abort,
    input  logic             calculate_start,
    input  logic [2:0]       order,
    input  logic             engine_done,
    output logic             pop_order_en,
    output logic             engine_start,
    output logic [2:0]       engine_sel,
    output logic             task_busy,
    output logic             task_done,
    output logic             task_error,
    output logic [2:0]       err_code,
    output logic [CNT_W-1:0] order_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_POP,
        S_LATCH,
        S_DISPATCH,
        S_BUSY,
        S_FINISH,
        S_ERROR
    } state_t;

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_ORDERS);

    state_t            state, state_n;
    logic [WDOG_W-1:0] wdog, wdog_n;
    logic [2:0]        sel_n, err_n;
    logic [CNT_W-1:0]  count_n;

    always_ff @(posedge system_clk) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            wdog         <= '0;
            pop_order_en <= 1'b0;
            engine_start <= 1'b0;
            engine_sel   <= '0;
            task_busy    <= 1'b0;
            task_done    <= 1'b0;
            task_error   <= 1'b0;
            err_code     <= '0;
            order_count  <= '0;
        end else begin
            state        <= state_n;
            wdog         <= wdog_n;
            engine_sel   <= sel_n;
            err_code     <= err_n;
            order_count  <= count_n;
            // Pulse/level outputs are registered decodes of the state being entered.
            pop_order_en <= (state_n == S_POP);
            engine_start <= (state_n == S_DISPATCH);
            task_done    <= (state_n == S_FINISH);
            task_error   <= (state_n == S_ERROR);
            task_busy    <= (state_n != S_IDLE) && (state_n != S_ERROR);
        end
    end

    always_comb begin
        state_n = state;
        wdog_n  = wdog;
        sel_n   = engine_sel;
        err_n   = err_code;
        count_n = order_count;

        case (state)
            S_IDLE: begin
                if (task_start) begin
                    state_n = S_POP;
                    count_n = '0;
                    err_n   = '0;
                end
            end
            S_POP: state_n = S_LATCH;
            S_LATCH: begin
                if (!calculate_start) begin
                    state_n = S_ERROR;
                    err_n   = 3'd4;
                end else if (order == 3'd5) begin
                    state_n = S_FINISH;
                end else if (order >= 3'd1 && order <= 3'd4) begin
                    // Select and count are updated on entry to DISPATCH so that
                    // engine_sel is already valid alongside engine_start.
                    state_n = S_DISPATCH;
                    sel_n   = order;
                    count_n = (order_count == MAX_CNT) ? order_count : order_count + 1'b1;
                end else begin
                    state_n = S_ERROR;
                    err_n   = 3'd1;
                end
            end
            S_DISPATCH: begin
                state_n = S_BUSY;
                wdog_n  = '0;
            end
            S_BUSY: begin
                // Timeout fires on the BUSY cycle that brings the watchdog to
                // all-ones, i.e. after 2^WDOG_W-1 BUSY cycles; done has priority.
                wdog_n = wdog + 1'b1;
                if (engine_done) begin
                    if (order_count == MAX_CNT) begin
                        state_n = S_ERROR;
                        err_n   = 3'd2;
                    end else begin
                        state_n = S_POP;
                    end
                end else if (wdog_n == '1) begin
                    state_n = S_ERROR;
                    err_n   = 3'd3;
                end
            end
            S_FINISH: state_n = S_IDLE;
            S_ERROR:  state_n = S_ERROR;
            default:  state_n = S_IDLE;
        endcase

        if (abort) begin
            state_n = S_IDLE;
            err_n   = '0;
        end
    end

endmodule

// File: tb/tb_order_sequencer.sv
// tb_order_sequencer
//   Directed bench for order_sequencer with a reactive order-cache model
//   (strobe one cycle after each pop) and an engine model (done a programmable
//   number of cycles after each start; 0 = never).
module tb_order_sequencer;

    logic       system_clk;
    logic       rst_n;
    logic       task_start;
    logic       abort;
    logic       calculate_start;
    logic [2:0] order;
    logic       engine_done;
    logic       pop_order_en;
    logic       engine_start;
    logic [2:0] engine_sel;
    logic       task_busy;
    logic       task_done;
    logic       task_error;
    logic [2:0] err_code;
    logic [9:0] order_count;

    order_sequencer #(
        .CNT_W(10),
        .MAX_ORDERS(512),
        .WDOG_W(4)
    ) dut (
        .system_clk(system_clk),
        .rst_n(rst_n),
        .task_start(task_start),
        .abort(abort),
        .calculate_start(calculate_start),
        .order(order),
        .engine_done(engine_done),
        .pop_order_en(pop_order_en),
        .engine_start(engine_start),
        .engine_sel(engine_sel),
        .task_busy(task_busy),
        .task_done(task_done),
        .task_error(task_error),
        .err_code(err_code),
        .order_count(order_count)
    );

    initial system_clk = 1'b0;
    always #5 system_clk = ~system_clk;

    // bench controls
    logic       tb_clr;
    logic [1:0] cache_mode;   // 0 list, 1 endless order 1, 2 no strobe
    int         eng_delay;
    logic [2:0] list [0:7];

    // model / counter state
    logic [2:0]  ptr;
    int          eng_cnt;
    int          pop_cnt, start_cnt, done_cnt;
    logic [11:0] sel_hist;

    int n_checks = 0;
    int n_pass   = 0;

    always @(posedge system_clk) begin
        if (tb_clr) begin
            ptr             <= '0;
            calculate_start <= 1'b0;
            order           <= '0;
        end else begin
            calculate_start <= pop_order_en && (cache_mode != 2'd2);
            if (pop_order_en) begin
                order <= (cache_mode == 2'd1) ? 3'd1 : list[ptr];
                ptr   <= ptr + 1'b1;
            end
        end
    end

    always @(posedge system_clk) begin
        if (tb_clr) begin
            eng_cnt     <= 0;
            engine_done <= 1'b0;
        end else begin
            engine_done <= (eng_cnt == 1);
            if (engine_start && eng_delay != 0) eng_cnt <= eng_delay;
            else if (eng_cnt != 0)              eng_cnt <= eng_cnt - 1;
        end
    end

    always @(posedge system_clk) begin
        if (tb_clr) begin
            pop_cnt   <= 0;
            start_cnt <= 0;
            done_cnt  <= 0;
            sel_hist  <= '0;
        end else begin
            if (pop_order_en) pop_cnt <= pop_cnt + 1;
            if (engine_start) begin
                start_cnt <= start_cnt + 1;
                sel_hist  <= {sel_hist[8:0], engine_sel};
            end
            if (task_done) done_cnt <= done_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic clear_models();
        tb_clr = 1'b1;
        @(negedge system_clk);
        tb_clr = 1'b0;
    endtask

    task automatic start_task();
        task_start = 1'b1;
        @(negedge system_clk);
        task_start = 1'b0;
    endtask

    task automatic pulse_abort();
        abort = 1'b1;
        @(negedge system_clk);
        abort = 1'b0;
    endtask

    task automatic wait_done(input int max_cyc);
        for (int i = 0; i < max_cyc && !task_done; i++) @(negedge system_clk);
    endtask

    task automatic wait_error(input int max_cyc);
        for (int i = 0; i < max_cyc && !task_error; i++) @(negedge system_clk);
    endtask

    task automatic wait_start(input int max_cyc);
        for (int i = 0; i < max_cyc && !engine_start; i++) @(negedge system_clk);
    endtask

    initial begin
        rst_n      = 1'b0;
        task_start = 1'b0;
        abort      = 1'b0;
        tb_clr     = 1'b1;
        cache_mode = 2'd0;
        eng_delay  = 0;
        for (int i = 0; i < 8; i++) list[i] = 3'd5;

        // 1. reset, task_start held during reset
        repeat (2) @(negedge system_clk);
        tb_clr     = 1'b0;
        task_start = 1'b1;
        repeat (2) @(negedge system_clk);
        task_start = 1'b0;
        chk("rst_pop",    pop_order_en, 0);
        chk("rst_start",  engine_start, 0);
        chk("rst_sel",    engine_sel,   0);
        chk("rst_busy",   task_busy,    0);
        chk("rst_done",   task_done,    0);
        chk("rst_error",  task_error,   0);
        chk("rst_code",   err_code,     0);
        chk("rst_count",  order_count,  0);
        chk("rst_popcnt", pop_cnt,      0);
        rst_n = 1'b1;
        @(negedge system_clk);

        // 2. list {1,2,5}, engine done ~10 cycles after each start
        list[0] = 3'd1; list[1] = 3'd2; list[2] = 3'd5;
        eng_delay = 10;
        clear_models();
        start_task();
        chk("t2_pop_first", pop_order_en, 1);
        wait_done(200);
        chk("t2_done_seen", task_done, 1);
        chk("t2_busy_w_done", task_busy, 1);
        @(negedge system_clk);
        chk("t2_done_pulse", task_done, 0);
        chk("t2_busy_fall", task_busy, 0);
        chk("t2_pops", pop_cnt, 3);
        chk("t2_starts", start_cnt, 2);
        chk("t2_sels", sel_hist[5:0], 6'b001_010);
        chk("t2_done_cnt", done_cnt, 1);
        chk("t2_count", order_count, 2);
        chk("t2_err", task_error, 0);

        // 3. illegal order 6, then abort
        list[0] = 3'd6;
        clear_models();
        start_task();
        wait_error(50);
        chk("t3_error", task_error, 1);
        chk("t3_code", err_code, 1);
        chk("t3_nostart", start_cnt, 0);
        chk("t3_busy", task_busy, 0);
        pulse_abort();
        chk("t3_abort_err", task_error, 0);
        chk("t3_abort_code", err_code, 0);
        chk("t3_abort_busy", task_busy, 0);
        chk("t3_abort_pops", pop_cnt, 1);

        // missing strobe
        cache_mode = 2'd2;
        clear_models();
        start_task();
        wait_error(50);
        chk("t3b_code", err_code, 4);
        pulse_abort();
        cache_mode = 2'd0;

        // 4. watchdog: engine never answers, WDOG_W=4 -> 15 BUSY cycles
        list[0] = 3'd3; list[1] = 3'd5;
        eng_delay = 0;
        clear_models();
        start_task();
        wait_start(50);
        chk("t4_start_seen", engine_start, 1);
        chk("t4_sel", engine_sel, 3);
        repeat (15) @(negedge system_clk);
        chk("t4_no_err_yet", task_error, 0);
        @(negedge system_clk);
        chk("t4_error", task_error, 1);
        chk("t4_code", err_code, 3);
        pulse_abort();

        // done on the watchdog's last cycle wins
        list[0] = 3'd4; list[1] = 3'd5;
        eng_delay = 14;
        clear_models();
        start_task();
        wait_done(100);
        chk("t4b_done", task_done, 1);
        chk("t4b_noerr", err_code, 0);
        chk("t4b_count", order_count, 1);
        @(negedge system_clk);

        // 5. 512 orders without end code -> overflow
        cache_mode = 2'd1;
        eng_delay  = 1;
        clear_models();
        start_task();
        wait_error(5000);
        chk("t5_error", task_error, 1);
        chk("t5_code", err_code, 2);
        chk("t5_pops", pop_cnt, 512);
        chk("t5_starts", start_cnt, 512);
        chk("t5_count", order_count, 512);
        pulse_abort();
        cache_mode = 2'd0;

        // 6a. abort beats task_start in IDLE
        clear_models();
        abort      = 1'b1;
        task_start = 1'b1;
        @(negedge system_clk);
        abort      = 1'b0;
        task_start = 1'b0;
        chk("t6_busy", task_busy, 0);
        chk("t6_pop", pop_order_en, 0);
        @(negedge system_clk);
        chk("t6_pops", pop_cnt, 0);

        // 6b. reset during BUSY
        list[0] = 3'd2; list[1] = 3'd5;
        eng_delay = 0;
        clear_models();
        start_task();
        wait_start(50);
        repeat (3) @(negedge system_clk);
        chk("t6_pre_count", order_count, 1);
        chk("t6_pre_busy", task_busy, 1);
        rst_n = 1'b0;
        @(negedge system_clk);
        chk("t6_rst_count", order_count, 0);
        chk("t6_rst_busy", task_busy, 0);
        chk("t6_rst_sel", engine_sel, 0);
        chk("t6_rst_pop", pop_order_en, 0);
        chk("t6_rst_start", engine_start, 0);
        rst_n = 1'b1;
        @(negedge system_clk);
        chk("t6_post_busy", task_busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
